fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetch requests under a credit limit,
// queues in-order responses with their PCs, and flushes on branch/exception redirects.
module fetch_queue #(
    parameter int            N        = 64,
    parameter int            W        = 32,
    parameter int            DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCSrc_F,
    input  logic [N-1:0]             PCBranch_F,
    input  logic                     EProc_F,
    input  logic [N-1:0]             EVAddr_F,
    output logic                     imem_req_valid,
    output logic [N-1:0]             imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [W-1:0]             imem_rsp_data,
    output logic                     inst_valid,
    output logic [W-1:0]             inst,
    output logic [N-1:0]             inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW        = $clog2(DEPTH);
    localparam int             CW        = AW + 1;
    localparam logic [N-1:0]   PC_STEP   = N'(4);
    localparam logic [CW:0]    DEPTH_LIM = (CW+1)'(DEPTH);

    logic [N-1:0]  fpc;
    logic [N-1:0]  rpc;
    logic [CW-1:0] out;
    logic [CW-1:0] drop;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [W-1:0]  mem_data [DEPTH];
    logic [N-1:0]  mem_pc   [DEPTH];

    logic          redirect;
    logic [N-1:0]  target;
    logic [CW:0]   credit_sum;
    logic          accept;
    logic          push;
    logic          pop;

    // Exception vector wins over branch target when both redirect in one cycle.
    always_comb begin
        redirect   = PCSrc_F | EProc_F;
        target     = EProc_F ? EVAddr_F : PCBranch_F;
        credit_sum = {1'b0, count} + {1'b0, out};
        accept     = imem_req_valid & imem_req_ready;
        push       = imem_rsp_valid & (drop == '0) & ~redirect;
        pop        = inst_valid & inst_ready;
    end

    // Credits count both queued and in-flight entries, so a live response always has room.
    always_comb begin
        imem_req_valid = ~redirect & (credit_sum < DEPTH_LIM);
        imem_req_addr  = fpc;
        inst_valid     = (count != '0) & ~redirect;
        inst           = mem_data[head];
        inst_pc        = mem_pc[head];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            count <= '0;
            out   <= '0;
            drop  <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            out <= out + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect) begin
                // Everything still in flight belongs to the old stream and must be discarded.
                fpc   <= target;
                rpc   <= target;
                count <= '0;
                head  <= '0;
                tail  <= '0;
                drop  <= out - CW'(imem_rsp_valid);
            end else begin
                if (accept) begin
                    fpc <= fpc + PC_STEP;
                end
                if (push) begin
                    tail <= tail + AW'(1);
                    rpc  <= rpc + PC_STEP;
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[tail] <= imem_rsp_data;
            mem_pc[tail]   <= rpc;
        end
    end

    assert property (@(posedge clk) disable iff (reset) credit_sum <= DEPTH_LIM);
    assert property (@(posedge clk) disable iff (reset) !(push && !pop && (count == CW'(DEPTH))));

endmodule
